// File: rtl/score_keeper.sv
// score_keeper: two-player match scorer with a six-digit 7-segment display.
// Points are accepted only in PLAY. Each point is followed by a fixed pause,
// unless it wins the match. The WIN screen blinks until new_game.
module score_keeper #(
  parameter int WIN_SCORE    = 5,
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int BLINK_DIV    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       new_game,
  output logic [3:0] digit5,
  output logic [3:0] digit4,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       serve_ready,
  output logic       game_over,
  output logic [1:0] winner
);

  // Counters only ever hold 0..N-1, so clog2(N) bits are enough (min 1 bit).
  localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);

  // Display glyph codes
  localparam logic [3:0] C_BLANK = 4'hA;
  localparam logic [3:0] C_DASH  = 4'hB;
  localparam logic [3:0] C_P     = 4'hC;
  localparam logic [3:0] C_ONE   = 4'hD;
  localparam logic [3:0] C_TWO   = 4'hE;
  localparam logic [3:0] C_F     = 4'hF;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    PAUSE = 2'd1,
    WIN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [1:0]    winner_q, winner_d;
  logic [PW-1:0] pause_cnt_q, pause_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;   // 1 = WIN screen visible

  logic [3:0]    s1_inc;
  logic [3:0]    s2_inc;

  assign s1_inc = s1_q + 4'd1;
  assign s2_inc = s2_q + 4'd1;

  // State register with asynchronous reset into an empty PLAY match
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PLAY;
      s1_q        <= 4'd0;
      s2_q        <= 4'd0;
      winner_q    <= 2'b00;
      pause_cnt_q <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      winner_q    <= winner_d;
      pause_cnt_q <= pause_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Next-state logic: new_game overrides everything, points count only in PLAY
  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    winner_d    = winner_q;
    pause_cnt_d = pause_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (new_game) begin
      state_d     = PLAY;
      s1_d        = 4'd0;
      s2_d        = 4'd0;
      winner_d    = 2'b00;
      pause_cnt_d = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          // Simultaneous points are ambiguous and are dropped entirely
          if (p1_point && !p2_point) begin
            s1_d = s1_inc;
            if (s1_inc == WIN_VAL) begin
              state_d     = WIN;
              winner_d    = 2'b01;
              blink_cnt_d = '0;
              phase_d     = 1'b1;
            end else begin
              state_d     = PAUSE;
              pause_cnt_d = '0;
            end
          end else if (p2_point && !p1_point) begin
            s2_d = s2_inc;
            if (s2_inc == WIN_VAL) begin
              state_d     = WIN;
              winner_d    = 2'b10;
              blink_cnt_d = '0;
              phase_d     = 1'b1;
            end else begin
              state_d     = PAUSE;
              pause_cnt_d = '0;
            end
          end
        end
        PAUSE: begin
          if (pause_cnt_q == PAUSE_LAST) begin
            state_d     = PLAY;
            pause_cnt_d = '0;
          end else begin
            pause_cnt_d = pause_cnt_q + PW'(1);
          end
        end
        WIN: begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  // Display decode from registered state only
  always_comb begin
    digit5 = C_ONE;
    digit4 = s1_q;
    digit3 = C_DASH;
    digit2 = C_DASH;
    digit1 = C_TWO;
    digit0 = s2_q;
    if (state_q == WIN) begin
      if (phase_q) begin
        digit5 = C_P;
        digit4 = (winner_q == 2'b01) ? 4'd1 : 4'd2;
        digit3 = C_BLANK;
        digit2 = C_BLANK;
        digit1 = C_F;
        digit0 = C_BLANK;
      end else begin
        digit5 = C_BLANK;
        digit4 = C_BLANK;
        digit3 = C_BLANK;
        digit2 = C_BLANK;
        digit1 = C_BLANK;
        digit0 = C_BLANK;
      end
    end
  end

  assign serve_ready = (state_q == PLAY);
  assign game_over   = (state_q == WIN);
  assign winner      = winner_q;

endmodule
